// File: rtl/link_pkg.sv
// link_pkg: state encoding, requester ids and link timing defaults shared by
// the master and slave UART link schedulers.
package link_pkg;
  typedef enum logic [2:0] {IDLE, SEND, WAIT_TX, WAIT_RX, ERR} link_state_e;
  localparam logic REQ_ATTACK = 1'b0;
  localparam logic REQ_SYNC = 1'b1;
  localparam int LINK_DATA_W = 16;
  localparam int LINK_FRAME_CYC = 1800;
  localparam int LINK_REPLY_TO = 200000;
  localparam int LINK_MAX_RETRY = 3;
  function automatic int cnt_w(input int a, input int b);
    return $clog2((a > b ? a : b) + 1);
  endfunction
endpackage

// File: rtl/link_rr_arb.sv
// link_rr_arb: two-way round-robin grant; on a tie the requester that did not
// win last time is granted.
module link_rr_arb
  import link_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [1:0] valid_i,
  output logic [1:0] grant_o
);
  logic last_q, last_d;
  always_comb begin
    grant_o[0] = en_i & valid_i[0] & (~valid_i[1] | (last_q == REQ_SYNC));
    grant_o[1] = en_i & valid_i[1] & (~valid_i[0] | (last_q == REQ_ATTACK));
    last_d = grant_o[0] ? REQ_ATTACK : grant_o[1] ? REQ_SYNC : last_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) last_q <= REQ_SYNC;
    else last_q <= last_d;
endmodule

// File: rtl/uart_link_sched.sv
// uart_link_sched: shares the master-to-slave UART transmitter between the
// attack requester (needs a reply, with timeout and retry) and the sync requester.
module uart_link_sched
  import link_pkg::*;
#(
  parameter int DATA_W    = LINK_DATA_W,
  parameter int FRAME_CYC = LINK_FRAME_CYC,
  parameter int REPLY_TO  = LINK_REPLY_TO,
  parameter int MAX_RETRY = LINK_MAX_RETRY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_grant,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_grant,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_send,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic              reply_valid,
  output logic [DATA_W-1:0] reply_data,
  output logic              busy,
  output logic              link_err,
  output logic [1:0]        retry_cnt
);
  localparam int CW = cnt_w(FRAME_CYC, REPLY_TO);
  localparam logic [CW-1:0] CNT_MAX = '1;
  link_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d, reply_data_q, reply_data_d;
  logic id_q, id_d, reply_valid_q, reply_valid_d, link_err_q, link_err_d;
  logic [1:0] retry_q, retry_d, grant;
  // Gating with rst keeps the combinational grants low while reset is held.
  link_rr_arb u_arb (
    .clk(clk),
    .rst(rst),
    .en_i(state_q == IDLE && !rst),
    .valid_i({req1_valid, req0_valid}),
    .grant_o(grant)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    tx_data_d = tx_data_q;
    id_d = id_q;
    reply_data_d = reply_data_q;
    reply_valid_d = 1'b0;
    link_err_d = link_err_q;
    retry_d = retry_q;
    case (state_q)
      IDLE: if (|grant) begin
        state_d = SEND;
        tx_data_d = grant[0] ? req0_data : req1_data;
        id_d = grant[0] ? REQ_ATTACK : REQ_SYNC;
        retry_d = grant[0] ? 2'd0 : retry_q;
      end
      SEND: begin
        state_d = WAIT_TX;
        cnt_d = '0;
      end
      WAIT_TX: if (cnt_q == CW'(FRAME_CYC - 1)) begin
        state_d = (id_q == REQ_SYNC) ? IDLE : WAIT_RX;
        cnt_d = '0;
      end
      // A reply arriving in the timeout cycle takes priority over the resend.
      WAIT_RX: if (rx_valid) begin
        reply_data_d = rx_data;
        reply_valid_d = 1'b1;
        link_err_d = 1'b0;
        retry_d = '0;
        state_d = IDLE;
      end else if (cnt_q == CW'(REPLY_TO - 1)) begin
        state_d = (retry_q < 2'(MAX_RETRY)) ? SEND : ERR;
        retry_d = (retry_q < 2'(MAX_RETRY)) ? retry_q + 2'd1 : retry_q;
        link_err_d = (retry_q < 2'(MAX_RETRY)) ? link_err_q : 1'b1;
      end
      ERR: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      tx_data_q <= '0;
      id_q <= REQ_ATTACK;
      reply_data_q <= '0;
      reply_valid_q <= 1'b0;
      link_err_q <= 1'b0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      tx_data_q <= tx_data_d;
      id_q <= id_d;
      reply_data_q <= reply_data_d;
      reply_valid_q <= reply_valid_d;
      link_err_q <= link_err_d;
      retry_q <= retry_d;
    end
  assign req0_grant = grant[0];
  assign req1_grant = grant[1];
  assign tx_data = tx_data_q;
  assign tx_send = state_q == SEND;
  assign reply_valid = reply_valid_q;
  assign reply_data = reply_data_q;
  assign busy = state_q != IDLE;
  assign link_err = link_err_q;
  assign retry_cnt = retry_q;
endmodule

// File: tb/tb_uart_link_sched.sv
// tb_uart_link_sched: transaction-level reference model predicts grant winner,
// send times, reply timing and sticky error/retry state for each exchange.
module tb_uart_link_sched;
  localparam int FC = 1800, RT = 600, MR = 3, P = FC + RT + 1;
  logic clk = 0, rst = 1;
  logic req0_valid = 0, req1_valid = 0, rx_valid = 0;
  logic [15:0] req0_data = 0, req1_data = 0, rx_data = 0;
  logic req0_grant, req1_grant, tx_send, reply_valid, busy, link_err;
  logic [15:0] tx_data, reply_data;
  logic [1:0] retry_cnt;
  int n_chk = 0, n_err = 0;
  bit m_last = 1, m_err = 0;
  int m_retry = 0;
  logic [15:0] m_reply = 0;
  always #5 clk = ~clk;
  uart_link_sched #(.DATA_W(16), .FRAME_CYC(FC), .REPLY_TO(RT), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_grant(req0_grant),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_grant(req1_grant),
    .tx_data(tx_data), .tx_send(tx_send), .rx_valid(rx_valid), .rx_data(rx_data),
    .reply_valid(reply_valid), .reply_data(reply_data), .busy(busy),
    .link_err(link_err), .retry_cnt(retry_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  // ra: attempt index (0..MR) on which the slave replies, >MR means never.
  task automatic xact(input bit w0, input bit w1, input logic [15:0] d0, input logic [15:0] d1,
                      input int ra, input int off, input bit noise, input logic [15:0] rv);
    bit w;
    logic [15:0] ed;
    int n_att, t_rx, exp_idle, t_idle, t_rep, n_send, bad_t, bad_d, bad_r, stray, n_rep;
    int t_noise = 1 + FC / 2;
    w = (w0 && w1) ? !m_last : w1;
    ed = w ? d1 : d0;
    if (w) begin n_att = 1; t_rx = -1; exp_idle = FC + 2; end
    else if (ra <= MR) begin n_att = ra + 1; t_rx = 2 + ra * P + FC + off; exp_idle = t_rx + 1; end
    else begin n_att = MR + 1; t_rx = -1; exp_idle = 2 + (MR + 1) * P; end
    {t_idle, t_rep} = {-32'sd1, -32'sd1};
    {n_send, bad_t, bad_d, bad_r, stray, n_rep} = '0;
    @(posedge clk); #1;
    req0_valid = w0; req1_valid = w1; req0_data = d0; req1_data = d1;
    @(negedge clk);
    chk("grant0", req0_grant, !w);
    chk("grant1", req1_grant, w);
    chk("idle_busy", busy, 0);
    m_last = w;
    for (int t = 1; t <= exp_idle + 20 && t_idle < 0; t++) begin
      @(posedge clk); #1;
      if (t == 1) begin if (w) req1_valid = 0; else req0_valid = 0; end
      rx_valid = (t == t_rx) || (noise && t == t_noise);
      rx_data = (t == t_rx) ? rv : 16'hDEAD;
      @(negedge clk);
      if (tx_send) begin
        n_send++;
        if (w ? t != 1 : ((t - 1) % P != 0 || (t - 1) / P >= n_att)) bad_t++;
        if (int'(retry_cnt) != (w ? m_retry : (t - 1) / P)) bad_r++;
      end
      if (tx_data !== ed) bad_d++;
      if (req0_grant || req1_grant) stray++;
      if (reply_valid) begin n_rep++; t_rep = t; end
      if (!busy) t_idle = t;
      if (t == exp_idle - 1) begin req0_valid = 0; req1_valid = 0; end
    end
    rx_valid = 0; req0_valid = 0; req1_valid = 0;
    if (!w) begin
      if (ra <= MR) begin m_err = 0; m_retry = 0; m_reply = rv; end
      else begin m_err = 1; m_retry = MR; end
    end
    chk("idle_t", t_idle, exp_idle);
    chk("send_cnt", n_send, n_att);
    chk("send_time", bad_t, 0);
    chk("tx_hold", bad_d, 0);
    chk("send_retry", bad_r, 0);
    chk("stray_grant", stray, 0);
    chk("reply_cnt", n_rep, t_rx < 0 ? 0 : 1);
    chk("reply_t", t_rep, t_rx < 0 ? -1 : t_rx + 1);
    chk("reply_data", reply_data, m_reply);
    chk("link_err", link_err, m_err);
    chk("retry_cnt", retry_cnt, m_retry);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl", {req0_grant, req1_grant, tx_send, busy, reply_valid, link_err, retry_cnt}, 0);
    chk("rst_data", {tx_data, reply_data}, 0);
    @(posedge clk); #1 rst = 0;
    xact(0, 1, 16'h0, 16'h00A5, 9, 0, 0, 16'h0);
    xact(1, 0, 16'h1234, 16'h0, 0, 500, 1, 16'h0001);
    xact(1, 1, 16'h1111, 16'h2222, 0, 10, 0, 16'h0AAA);
    xact(1, 1, 16'h3333, 16'h2222, 0, 20, 0, 16'h0BBB);
    xact(1, 0, 16'h3333, 16'h0, 0, 30, 0, 16'h0CCC);
    xact(1, 0, 16'hBEEF, 16'h0, 9, 0, 0, 16'h0);
    xact(0, 1, 16'h0, 16'h5A00, 9, 0, 1, 16'h0);
    xact(1, 0, 16'hC0DE, 16'h0, 0, 100, 0, 16'h4242);
    xact(1, 0, 16'h7777, 16'h0, 1, RT - 1, 0, 16'h5555);
    xact(1, 0, 16'h8888, 16'h0, 0, RT - 1, 0, 16'h6666);
    for (int i = 0; i < 6; i++) begin
      bit a, b;
      a = 1'($urandom_range(0, 1));
      b = a ? 1'($urandom_range(0, 1)) : 1'b1;
      xact(a, b, 16'($urandom), 16'($urandom), $urandom_range(0, 1), $urandom_range(0, RT - 1),
           1'($urandom_range(0, 1)), 16'($urandom));
    end
    @(posedge clk); #1 req1_valid = 1; req1_data = 16'h5A5A;
    @(posedge clk); #1 req1_valid = 0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    @(posedge clk); #3 rst = 1; #1;
    chk("arst_ctl", {req0_grant, req1_grant, tx_send, busy, reply_valid, link_err, retry_cnt}, 0);
    chk("arst_data", {tx_data, reply_data}, 0);
    @(posedge clk); #1 rst = 0;
    m_last = 1; m_err = 0; m_retry = 0; m_reply = 0;
    repeat (3) begin @(negedge clk); chk("post_rst_busy", {busy, tx_send}, 0); end
    xact(1, 1, 16'hA0A0, 16'hB0B0, 0, 7, 0, 16'h0F0F);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
